// File: rtl/eth_parser_sequencer.sv
// Rx packet sequencer: runs the MAC decoder, reads the EtherType word, then hands the
// packet to the ARP or IP parser, starts transmit on success and releases the Rx buffer.
module eth_parser_sequencer #(
  parameter int unsigned Eth_WORD_WIDTH = 16,
  parameter int unsigned ETYPE_ADDR     = 6,
  parameter logic [15:0] ETYPE_ARP      = 16'h0806,
  parameter logic [15:0] ETYPE_IP       = 16'h0800,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Rx_Pkt_Ready,
  output logic                      Rx_Pkt_Done,
  output logic                      MAC_RQ,
  input  logic                      MAC_Next,
  input  logic                      MAC_Err,
  output logic                      ARP_RQ,
  input  logic                      ARP_Done,
  input  logic                      ARP_Err,
  output logic                      IP_RQ,
  input  logic                      IP_Done,
  input  logic                      IP_Err,
  output logic                      Rx_Addr_Own,
  output logic [10:0]               Rx_Addr,
  input  logic [Eth_WORD_WIDTH-1:0] Rx_Data,
  input  logic                      Tx_Busy,
  output logic                      Tx_Start,
  output logic                      Pkt_Drop,
  output logic [15:0]               Drop_Cnt
);

  localparam int unsigned WordW  = Eth_WORD_WIDTH;
  localparam int unsigned CntW   = 8;
  localparam int unsigned AddrW  = 11;
  localparam int unsigned DropW  = 16;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MAC       = 3'd1;
  localparam logic [2:0] ETYPE_ADR = 3'd2;
  localparam logic [2:0] ETYPE_CHK = 3'd3;
  localparam logic [2:0] ARP       = 3'd4;
  localparam logic [2:0] IP        = 3'd5;
  localparam logic [2:0] TX_WAIT   = 3'd6;
  localparam logic [2:0] RELEASE   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
  logic [AddrW-1:0] rx_addr_q, rx_addr_d;
  logic             mac_rq_q, mac_rq_d;
  logic             arp_rq_q, arp_rq_d;
  logic             ip_rq_q, ip_rq_d;
  logic             rx_addr_own_q, rx_addr_own_d;
  logic             rx_pkt_done_q, rx_pkt_done_d;
  logic             tx_start_q, tx_start_d;
  logic             pkt_drop_q, pkt_drop_d;

  logic             stage_to;
  logic             in_stage;
  logic             drop;
  logic             tx_go;

  // Next state, stage counter and the registered-output image of the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop       = 1'b0;
    tx_go      = 1'b0;
    stage_to   = (cnt_q == CntW'(TIMEOUT - 1));
    in_stage   = (state_q == MAC) || (state_q == ARP) || (state_q == IP);

    case (state_q)
      IDLE: begin
        if (Rx_Pkt_Ready) state_d = MAC;
      end
      MAC: begin
        if (MAC_Next)                  state_d = ETYPE_ADR;
        else if (MAC_Err || stage_to)  drop = 1'b1;
      end
      ETYPE_ADR: begin
        state_d = ETYPE_CHK;
      end
      ETYPE_CHK: begin
        if (Rx_Data == WordW'(ETYPE_ARP))     state_d = ARP;
        else if (Rx_Data == WordW'(ETYPE_IP)) state_d = IP;
        else                                  drop = 1'b1;
      end
      ARP: begin
        if (ARP_Done)                  state_d = TX_WAIT;
        else if (ARP_Err || stage_to)  drop = 1'b1;
      end
      IP: begin
        if (IP_Done)                   state_d = TX_WAIT;
        else if (IP_Err || stage_to)   drop = 1'b1;
      end
      TX_WAIT: begin
        if (!Tx_Busy) begin
          tx_go   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (drop) state_d = RELEASE;

    // Any state change restarts the count, so each stage starts from zero.
    if (state_d != state_q) cnt_d = '0;
    else if (in_stage)      cnt_d = cnt_q + CntW'(1);

    mac_rq_d      = (state_d == MAC);
    arp_rq_d      = (state_d == ARP);
    ip_rq_d       = (state_d == IP);
    rx_addr_own_d = (state_d == ETYPE_ADR) || (state_d == ETYPE_CHK);
    rx_addr_d     = rx_addr_own_d ? AddrW'(ETYPE_ADDR) : '0;
    rx_pkt_done_d = (state_d == RELEASE);
    tx_start_d    = tx_go;
    pkt_drop_d    = drop;
    drop_cnt_d    = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DropW'(1) : drop_cnt_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      drop_cnt_q    <= '0;
      rx_addr_q     <= '0;
      mac_rq_q      <= 1'b0;
      arp_rq_q      <= 1'b0;
      ip_rq_q       <= 1'b0;
      rx_addr_own_q <= 1'b0;
      rx_pkt_done_q <= 1'b0;
      tx_start_q    <= 1'b0;
      pkt_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      rx_addr_q     <= rx_addr_d;
      mac_rq_q      <= mac_rq_d;
      arp_rq_q      <= arp_rq_d;
      ip_rq_q       <= ip_rq_d;
      rx_addr_own_q <= rx_addr_own_d;
      rx_pkt_done_q <= rx_pkt_done_d;
      tx_start_q    <= tx_start_d;
      pkt_drop_q    <= pkt_drop_d;
    end
  end

  assign MAC_RQ      = mac_rq_q;
  assign ARP_RQ      = arp_rq_q;
  assign IP_RQ       = ip_rq_q;
  assign Rx_Addr_Own = rx_addr_own_q;
  assign Rx_Addr     = rx_addr_q;
  assign Rx_Pkt_Done = rx_pkt_done_q;
  assign Tx_Start    = tx_start_q;
  assign Pkt_Drop    = pkt_drop_q;
  assign Drop_Cnt    = drop_cnt_q;

endmodule

// File: tb/tb_eth_parser_sequencer.sv
// Bench for eth_parser_sequencer: each packet scenario is expanded into a per-cycle
// timeline of inputs and expected outputs, which is then replayed and compared cycle by cycle.
module tb_eth_parser_sequencer;

  localparam int unsigned TIMEOUT = 255;
  localparam logic [10:0] EADDR   = 11'd6;
  localparam logic [15:0] ARP_T   = 16'h0806;
  localparam logic [15:0] IP_T    = 16'h0800;

  logic        Clock;
  logic        Reset;
  logic        Rx_Pkt_Ready;
  logic        Rx_Pkt_Done;
  logic        MAC_RQ, MAC_Next, MAC_Err;
  logic        ARP_RQ, ARP_Done, ARP_Err;
  logic        IP_RQ, IP_Done, IP_Err;
  logic        Rx_Addr_Own;
  logic [10:0] Rx_Addr;
  logic [15:0] Rx_Data;
  logic        Tx_Busy, Tx_Start;
  logic        Pkt_Drop;
  logic [15:0] Drop_Cnt;

  eth_parser_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .Rx_Pkt_Ready(Rx_Pkt_Ready), .Rx_Pkt_Done(Rx_Pkt_Done),
    .MAC_RQ(MAC_RQ), .MAC_Next(MAC_Next), .MAC_Err(MAC_Err),
    .ARP_RQ(ARP_RQ), .ARP_Done(ARP_Done), .ARP_Err(ARP_Err),
    .IP_RQ(IP_RQ), .IP_Done(IP_Done), .IP_Err(IP_Err),
    .Rx_Addr_Own(Rx_Addr_Own), .Rx_Addr(Rx_Addr), .Rx_Data(Rx_Data),
    .Tx_Busy(Tx_Busy), .Tx_Start(Tx_Start),
    .Pkt_Drop(Pkt_Drop), .Drop_Cnt(Drop_Cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic ready, mac_next, mac_err, arp_done, arp_err, ip_done, ip_err, tx_busy;
  } in_t;

  typedef struct packed {
    logic        mac_rq, arp_rq, ip_rq, own;
    logic [10:0] addr;
    logic        tx_start, drop, done;
    logic [15:0] dcnt;
  } exp_t;

  in_t         in_q[$];
  exp_t        ex_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cur_dcnt;
  logic [15:0] etype_mem;
  logic        prev_own;
  logic [10:0] prev_addr;
  int          t_mac, t_arp, t_ip, t_own, t_txs, t_drop, t_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_tally();
    t_mac = 0; t_arp = 0; t_ip = 0; t_own = 0; t_txs = 0; t_drop = 0; t_done = 0;
  endtask

  task automatic apply(input in_t i);
    Rx_Pkt_Ready = i.ready;
    MAC_Next = i.mac_next; MAC_Err = i.mac_err;
    ARP_Done = i.arp_done; ARP_Err = i.arp_err;
    IP_Done  = i.ip_done;  IP_Err  = i.ip_err;
    Tx_Busy  = i.tx_busy;
  endtask

  // One clock: compare outputs to the timeline, then drive this cycle's inputs.
  task automatic step(input in_t i, input exp_t e);
    @(posedge Clock); #1;
    chk("mac_rq",   32'(MAC_RQ),      32'(e.mac_rq));
    chk("arp_rq",   32'(ARP_RQ),      32'(e.arp_rq));
    chk("ip_rq",    32'(IP_RQ),       32'(e.ip_rq));
    chk("addr_own", 32'(Rx_Addr_Own), 32'(e.own));
    chk("rx_addr",  32'(Rx_Addr),     32'(e.addr));
    chk("tx_start", 32'(Tx_Start),    32'(e.tx_start));
    chk("pkt_drop", 32'(Pkt_Drop),    32'(e.drop));
    chk("pkt_done", 32'(Rx_Pkt_Done), 32'(e.done));
    chk("drop_cnt", 32'(Drop_Cnt),    32'(e.dcnt));
    if (MAC_RQ)      t_mac++;
    if (ARP_RQ)      t_arp++;
    if (IP_RQ)       t_ip++;
    if (Rx_Addr_Own) t_own++;
    if (Tx_Start)    t_txs++;
    if (Pkt_Drop)    t_drop++;
    if (Rx_Pkt_Done) t_done++;
    // Rx buffer: data for the address presented last cycle
    Rx_Data   = (prev_own && prev_addr == EADDR) ? etype_mem : 16'hDEAD;
    prev_own  = Rx_Addr_Own;
    prev_addr = Rx_Addr;
    apply(i);
  endtask

  task automatic push(input in_t i, input exp_t e);
    in_q.push_back(i);
    ex_q.push_back(e);
  endtask

  task automatic run_all();
    while (in_q.size() > 0) step(in_q.pop_front(), ex_q.pop_front());
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) step(in_q.pop_front(), ex_q.pop_front());
  endtask

  task automatic add_idle(input int n);
    in_t  i;
    exp_t e;
    i = '0; e = '0; e.dcnt = 16'(cur_dcnt);
    for (int k = 0; k < n; k++) push(i, e);
  endtask

  // Expand one packet into its timeline. An index of -1 means the response never comes.
  task automatic gen_pkt(input int mac_idx, input bit m_next, input bit m_err,
                         input logic [15:0] etype, input int st_idx, input bit s_done,
                         input bit s_err, input int busy, input bit spur);
    in_t  i;
    exp_t e;
    int   lm, ls;
    bit   pass, arp;
    etype_mem = etype;
    i = '0; i.ready = 1'b1; e = '0; e.dcnt = 16'(cur_dcnt);
    push(i, e);
    lm = (mac_idx < 0) ? int'(TIMEOUT) : mac_idx + 1;
    for (int k = 0; k < lm; k++) begin
      i = '0; i.ready = 1'b1;
      if (spur) begin i.arp_done = 1'b1; i.arp_err = 1'b1; i.ip_done = 1'b1; i.ip_err = 1'b1; end
      if (k == mac_idx) begin i.mac_next = m_next; i.mac_err = m_err; end
      e = '0; e.dcnt = 16'(cur_dcnt); e.mac_rq = 1'b1;
      push(i, e);
    end
    pass = (mac_idx >= 0) && m_next;
    if (pass) begin
      for (int k = 0; k < 2; k++) begin
        i = '0; i.ready = 1'b1;
        e = '0; e.dcnt = 16'(cur_dcnt); e.own = 1'b1; e.addr = EADDR;
        push(i, e);
      end
      arp  = (etype == ARP_T);
      pass = arp || (etype == IP_T);
      if (pass) begin
        ls = (st_idx < 0) ? int'(TIMEOUT) : st_idx + 1;
        for (int k = 0; k < ls; k++) begin
          i = '0; i.ready = 1'b1;
          if (spur) begin
            i.mac_next = 1'b1; i.mac_err = 1'b1;
            if (arp) i.ip_done = 1'b1; else i.arp_done = 1'b1;
          end
          if (k == st_idx) begin
            if (arp) begin i.arp_done = s_done; i.arp_err = s_err; end
            else     begin i.ip_done  = s_done; i.ip_err  = s_err; end
          end
          e = '0; e.dcnt = 16'(cur_dcnt); e.arp_rq = arp; e.ip_rq = !arp;
          push(i, e);
        end
        pass = (st_idx >= 0) && s_done;
        if (pass) begin
          for (int k = 0; k <= busy; k++) begin
            i = '0; i.ready = 1'b1; i.tx_busy = (k < busy);
            e = '0; e.dcnt = 16'(cur_dcnt);
            push(i, e);
          end
        end
      end
    end
    if (!pass && cur_dcnt < 65535) cur_dcnt++;
    i = '0; i.ready = 1'b1;
    e = '0; e.dcnt = 16'(cur_dcnt); e.done = 1'b1; e.tx_start = pass; e.drop = !pass;
    push(i, e);
  endtask

  task automatic pkt(input int mac_idx, input bit m_next, input bit m_err,
                     input logic [15:0] etype, input int st_idx, input bit s_done,
                     input bit s_err, input int busy, input bit spur);
    clr_tally();
    gen_pkt(mac_idx, m_next, m_err, etype, st_idx, s_done, s_err, busy, spur);
    run_all();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rq"},   32'({MAC_RQ, ARP_RQ, IP_RQ}), 32'd0);
    chk({tag, "_own"},  32'(Rx_Addr_Own), 32'd0);
    chk({tag, "_addr"}, 32'(Rx_Addr), 32'd0);
    chk({tag, "_puls"}, 32'({Tx_Start, Pkt_Drop, Rx_Pkt_Done}), 32'd0);
    chk({tag, "_dcnt"}, 32'(Drop_Cnt), 32'd0);
  endtask

  initial begin
    in_t z;
    z = '0;
    Reset = 1'b1; apply(z); Rx_Data = 16'h0;
    prev_own = 1'b0; prev_addr = '0; cur_dcnt = 0; etype_mem = 16'h0;
    #12;
    chk_all_zero("reset");
    @(negedge Clock); Reset = 1'b0;

    // Rx_Pkt_Ready low: nothing starts
    add_idle(3); run_all();

    pkt(7, 1, 0, ARP_T, 20, 1, 0, 0, 0);
    chk("lit_arp_mac", 32'(t_mac), 32'd8);
    chk("lit_arp_rq",  32'(t_arp), 32'd21);
    chk("lit_arp_txs", 32'(t_txs), 32'd1);
    chk("lit_arp_done", 32'(t_done), 32'd1);
    chk("lit_arp_dcnt", 32'(Drop_Cnt), 32'd0);

    pkt(3, 0, 1, ARP_T, 0, 0, 0, 0, 0);
    chk("lit_macerr_drop", 32'(t_drop), 32'd1);
    chk("lit_macerr_dcnt", 32'(Drop_Cnt), 32'd1);
    chk("lit_macerr_rq",  32'(t_arp + t_ip), 32'd0);
    chk("lit_macerr_txs", 32'(t_txs), 32'd0);
    chk("lit_macerr_done", 32'(t_done), 32'd1);

    pkt(0, 1, 0, 16'h86DD, 0, 0, 0, 0, 0);
    chk("lit_etype_own",  32'(t_own), 32'd2);
    chk("lit_etype_drop", 32'(t_drop), 32'd1);

    pkt(2, 1, 0, IP_T, -1, 0, 0, 0, 0);
    chk("lit_ipto_rq",   32'(t_ip), 32'd255);
    chk("lit_ipto_drop", 32'(t_drop), 32'd1);

    pkt(4, 1, 0, IP_T, 5, 1, 1, 100, 0);
    chk("lit_busy_txs",  32'(t_txs), 32'd1);
    chk("lit_busy_drop", 32'(t_drop), 32'd0);

    pkt(2, 1, 1, ARP_T, 4, 0, 1, 0, 1);
    chk("lit_arperr_drop", 32'(t_drop), 32'd1);
    pkt(1, 1, 0, ARP_T, 3, 1, 1, 3, 1);
    chk("lit_arpboth_txs", 32'(t_txs), 32'd1);
    pkt(-1, 0, 0, ARP_T, 0, 0, 0, 0, 1);
    chk("lit_macto_rq",   32'(t_mac), 32'd255);
    chk("lit_macto_dcnt", 32'(Drop_Cnt), 32'd5);
    add_idle(2); run_all();

    // Reset in the middle of the ARP stage
    clr_tally();
    gen_pkt(1, 1, 0, ARP_T, -1, 0, 0, 0, 0);
    run_n(15);
    in_q.delete(); ex_q.delete();
    chk("pre_reset_arp", 32'(ARP_RQ), 32'd1);
    #1 Reset = 1'b1;
    #1 chk_all_zero("async_rst");
    apply(z);
    cur_dcnt = 0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0; prev_own = 1'b0;
    add_idle(3); run_all();
    chk("lit_rst_done", 32'(t_done), 32'd0);
    chk("lit_rst_puls", 32'(t_drop + t_txs), 32'd0);
    pkt(0, 1, 0, ARP_T, 2, 1, 0, 1, 0);
    chk("lit_recover_txs", 32'(t_txs), 32'd1);

    // Preload the drop counter close to its ceiling
    #1 force dut.drop_cnt_q = 16'hFFFD;
    #1 release dut.drop_cnt_q;
    cur_dcnt = 65533;
    for (int n = 0; n < 4; n++) pkt(0, 0, 1, ARP_T, 0, 0, 0, 0, 0);
    chk("lit_sat_dcnt", 32'(Drop_Cnt), 32'h0000FFFF);
    add_idle(2); run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_parser_sequencer.md
ETH_PARSER_SEQUENCER -- requirements
Module: eth_parser_sequencer

Interface
REQ-001 SHALL have parameter Eth_WORD_WIDTH, default 16: Rx buffer word width.
REQ-002 SHALL have parameter ETYPE_ADDR, default 6: Rx buffer word address of the EtherType word.
REQ-003 SHALL have parameters ETYPE_ARP, default 16'h0806, and ETYPE_IP, default 16'h0800: dispatched EtherType codes.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles per parser stage, 8-bit range 1..255.
REQ-005 Clock  in  1  single system clock; all logic on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 Rx_Pkt_Ready  in  1  level; a complete packet is waiting in the Rx buffer.
REQ-008 Rx_Pkt_Done  out  1  one-cycle pulse; Rx buffer released to the receiver.
REQ-009 MAC_RQ / MAC_Next / MAC_Err  out/in/in  1 each  MAC decoder request level, pass pulse, error level.
REQ-010 ARP_RQ / ARP_Done / ARP_Err  out/in/in  1 each  ARP parser request level, success pulse, error pulse.
REQ-011 IP_RQ / IP_Done / IP_Err  out/in/in  1 each  IP parser request level, success pulse, error pulse.
REQ-012 Rx_Addr_Own  out  1  high when the sequencer owns the Rx read port.
REQ-013 Rx_Addr  out  11  Rx read address, valid while Rx_Addr_Own is high.
REQ-014 Rx_Data  in  Eth_WORD_WIDTH  Rx read data, one-cycle latency after Rx_Addr.
REQ-015 Tx_Busy / Tx_Start  in/out  1 each  transmitter busy level; one-cycle transmit start pulse.
REQ-016 Pkt_Drop  out  1  one-cycle pulse when a packet is discarded.
REQ-017 Drop_Cnt  out  16  count of dropped packets, saturating at 16'hFFFF.

Function
REQ-018 SHALL implement the states IDLE, MAC, ETYPE_ADR, ETYPE_CHK, ARP, IP, TX_WAIT and RELEASE.
REQ-019 In IDLE with Rx_Pkt_Ready=1, SHALL go to MAC next cycle.
REQ-020 MAC_RQ SHALL be high exactly while in MAC; the rising edge gives the decoder its start.
REQ-021 In MAC: MAC_Next=1 -> ETYPE_ADR; MAC_Err=1 with MAC_Next=0 -> drop; timeout -> drop.
REQ-022 If MAC_Next and MAC_Err are both high in the same cycle, MAC_Next SHALL win.
REQ-023 In ETYPE_ADR, SHALL assert Rx_Addr_Own=1 and Rx_Addr=ETYPE_ADDR, then go to ETYPE_CHK.
REQ-024 In ETYPE_CHK, SHALL hold Rx_Addr_Own and Rx_Addr and sample Rx_Data.
REQ-025 From ETYPE_CHK: ETYPE_ARP -> ARP; ETYPE_IP -> IP; any other value -> drop.
REQ-026 In ARP, SHALL hold ARP_RQ high; Done -> TX_WAIT; Err or timeout -> drop; Done wins over Err.
REQ-027 In IP, SHALL hold IP_RQ high; Done -> TX_WAIT; Err or timeout -> drop; Done wins over Err.
REQ-028 Timeout: 8-bit stage counter cleared on entry to MAC, ARP or IP, incremented each cycle in those states.
REQ-029 Timeout SHALL fire when the counter equals TIMEOUT-1 and no success input is present in that cycle.
REQ-030 In TX_WAIT: Tx_Busy=0 -> one-cycle Tx_Start pulse and go to RELEASE; Tx_Busy=1 -> wait, with no timeout.
REQ-031 Drop SHALL: give a one-cycle Pkt_Drop pulse, increment Drop_Cnt (saturating), and go to RELEASE.
REQ-032 In RELEASE, SHALL pulse Rx_Pkt_Done for one cycle, then return to IDLE.
REQ-033 Rx_Pkt_Ready still high in IDLE after RELEASE SHALL start a new packet, giving at least one idle cycle between packets.
REQ-034 At most one of MAC_RQ, ARP_RQ and IP_RQ SHALL be high at any time.
REQ-035 Every output SHALL be registered (glitch-free); Rx_Addr SHALL be 0 when Rx_Addr_Own=0.
REQ-036 Done, Err and Next inputs arriving outside their stage SHALL be ignored.

Reset
REQ-037 Reset=1 SHALL force IDLE immediately and asynchronously.
REQ-038 Reset=1 SHALL set all request outputs, pulse outputs and Rx_Addr_Own to 0, and set Rx_Addr=0, Drop_Cnt=0 and the stage counter=0.
REQ-039 Reset mid-packet SHALL abandon the packet with no Rx_Pkt_Done, Pkt_Drop or Tx_Start.
REQ-040 After Reset release, a packet SHALL be accepted only if Rx_Pkt_Ready is high in IDLE.

Verification
REQ-041 Check: Rx_Pkt_Ready=1, MAC_Next after 7 cycles, Rx_Data=16'h0806, ARP_Done after 20 cycles, Tx_Busy=0 -> ARP_RQ high, one Tx_Start, one Rx_Pkt_Done, Drop_Cnt=0.
REQ-042 Check: MAC_Err=1 -> one Pkt_Drop, Drop_Cnt=1, Rx_Pkt_Done, no ARP_RQ, no IP_RQ, no Tx_Start.
REQ-043 Check: MAC passes, Rx_Data=16'h86DD -> drop; Rx_Addr=6 with Rx_Addr_Own=1 for exactly 2 cycles.
REQ-044 Check: IP selected and IP_Done never arrives -> IP_RQ high exactly 255 cycles, then Pkt_Drop.
REQ-045 Check: Tx_Busy=1 for 100 cycles after IP_Done -> Tx_Start the cycle after Tx_Busy falls; same-cycle IP_Done+IP_Err -> success path.
REQ-046 Check: Reset asserted while in ARP -> outputs 0 at once, no Rx_Pkt_Done; 65536 forced drops -> Drop_Cnt holds 16'hFFFF.
